// File: rtl/instruction_encoder.sv
// Program-load encoder: packs instruction fields into 16-bit words, range-checks
// immediates and streams legal words into instruction memory at consecutive addresses.
module instruction_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [2:0]        opcode,
    input  logic [1:0]        op,
    input  logic [2:0]        rn,
    input  logic [2:0]        rd,
    input  logic [2:0]        rm,
    input  logic [1:0]        shift,
    input  logic [15:0]       imm,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] FMT_REG3 = 3'd0;
    localparam logic [2:0] FMT_REG2 = 3'd1;
    localparam logic [2:0] FMT_IMM8 = 3'd2;
    localparam logic [2:0] FMT_IMM5 = 3'd3;
    localparam logic [2:0] FMT_BARE = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_next_addr;
    logic [ADDR_W:0]   r_word_count;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_din;
    logic              r_err;

    logic [15:0]       w_word;
    logic              w_legal;
    logic              w_accept;
    logic              w_top;

    // A signed immediate fits in n bits when everything from the sign bit up agrees.
    function automatic logic fits_imm8(input logic [15:0] v);
        return (v[15:7] == 9'h000) || (v[15:7] == 9'h1FF);
    endfunction

    function automatic logic fits_imm5(input logic [15:0] v);
        return (v[15:4] == 12'h000) || (v[15:4] == 12'hFFF);
    endfunction

    // Field packing per format; unused fields are forced to zero so words decode back exactly.
    always_comb begin
        w_word  = 16'h0000;
        w_legal = 1'b0;
        case (fmt)
            FMT_REG3: begin
                w_word  = {opcode, op, rn, rd, shift, rm};
                w_legal = 1'b1;
            end
            FMT_REG2: begin
                w_word  = {opcode, op, 3'b000, rd, shift, rm};
                w_legal = 1'b1;
            end
            FMT_IMM8: begin
                w_word  = {opcode, op, rn, imm[7:0]};
                w_legal = fits_imm8(imm);
            end
            FMT_IMM5: begin
                w_word  = {opcode, op, rn, rd, imm[4:0]};
                w_legal = fits_imm5(imm);
            end
            FMT_BARE: begin
                w_word  = {opcode, op, 11'b000_0000_0000};
                w_legal = 1'b1;
            end
            default: begin
                w_word  = 16'h0000;
                w_legal = 1'b0;
            end
        endcase
    end

    // A start pulse blocks acceptance in the same cycle so the restart is clean.
    assign in_ready = (r_state == ST_RUN) && !start;
    assign w_accept = in_valid && in_ready;
    assign w_top    = (r_next_addr == {ADDR_W{1'b1}});

    // Load-path state machine: address/count bookkeeping and registered write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_next_addr  <= '0;
            r_word_count <= '0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= 16'h0000;
            r_err        <= 1'b0;
        end else if (start) begin
            r_state      <= ST_RUN;
            r_next_addr  <= '0;
            r_word_count <= '0;
            r_mem_write  <= 1'b0;
            r_err        <= 1'b0;
        end else if (w_accept) begin
            if (w_legal) begin
                r_mem_write  <= 1'b1;
                r_mem_addr   <= r_next_addr;
                r_mem_din    <= w_word;
                r_word_count <= r_word_count + (ADDR_W+1)'(1'b1);
                if (w_top) begin
                    r_state <= ST_FULL;
                end else begin
                    r_next_addr <= r_next_addr + ADDR_W'(1'b1);
                end
            end else begin
                r_mem_write <= 1'b0;
                r_err       <= 1'b1;
            end
        end else begin
            r_mem_write <= 1'b0;
        end
    end

    assign mem_write  = r_mem_write;
    assign mem_addr   = r_mem_addr;
    assign mem_din    = r_mem_din;
    assign word_count = r_word_count;
    assign done       = (r_state == ST_FULL);
    assign err        = r_err;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: a default-width instance for encoding,
// rejection and reset behaviour, plus an ADDR_W=2 instance for the full condition.
module tb_instruction_encoder;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    // Main instance (ADDR_W = 8)
    logic        start = 1'b0, in_valid = 1'b0, in_ready;
    logic [2:0]  fmt = 3'd0, opcode = 3'd0, rn = 3'd0, rd = 3'd0, rm = 3'd0;
    logic [1:0]  op = 2'd0, shift = 2'd0;
    logic [15:0] imm = 16'h0000;
    logic        mem_write, done, err;
    logic [7:0]  mem_addr;
    logic [15:0] mem_din;
    logic [8:0]  word_count;

    instruction_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .fmt(fmt), .opcode(opcode), .op(op), .rn(rn),
        .rd(rd), .rm(rm), .shift(shift), .imm(imm), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_din(mem_din), .word_count(word_count),
        .done(done), .err(err)
    );

    // Small instance (ADDR_W = 2)
    logic        s_start = 1'b0, s_in_valid = 1'b0, s_in_ready;
    logic [2:0]  s_opcode = 3'd0;
    logic        s_mem_write, s_done, s_err;
    logic [1:0]  s_mem_addr;
    logic [15:0] s_mem_din;
    logic [2:0]  s_word_count;

    instruction_encoder #(.ADDR_W(2)) dut_small (
        .clk(clk), .reset_n(reset_n), .start(s_start), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .fmt(3'd4), .opcode(s_opcode), .op(2'd1), .rn(3'd0),
        .rd(3'd0), .rm(3'd0), .shift(2'd0), .imm(16'h0000), .mem_write(s_mem_write),
        .mem_addr(s_mem_addr), .mem_din(s_mem_din), .word_count(s_word_count),
        .done(s_done), .err(s_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [2:0] opc, input logic [1:0] o,
                         input logic [2:0] n, input logic [2:0] d, input logic [1:0] sh,
                         input logic [2:0] m, input logic [15:0] im);
        in_valid = 1'b1;
        fmt = f; opcode = opc; op = o; rn = n; rd = d; shift = sh; rm = m; imm = im;
    endtask

    initial begin
        // Reset values, with a bundle offered that must not be taken
        drive(3'd0, 3'd7, 2'd3, 3'd7, 3'd7, 2'd3, 3'd7, 16'hFFFF);
        step(); step();
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din", mem_din, 0);
        check("rst_word_count", word_count, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset_n = 1'b1;
        step();
        check("idle_in_ready", in_ready, 0);
        check("idle_no_write", mem_write, 0);

        // start with simultaneous valid: not accepted
        start = 1'b1;
        #1;
        check("start_in_ready_low", in_ready, 0);
        step();
        start = 1'b0;
        check("start_no_write", mem_write, 0);
        check("start_wc", word_count, 0);

        // IMM8 with negative immediate
        drive(3'd2, 3'b110, 2'b10, 3'd3, 3'd0, 2'd0, 3'd0, 16'hFFFB);
        #1;
        check("run_in_ready", in_ready, 1);
        step();
        check("imm8_we", mem_write, 1);
        check("imm8_addr", mem_addr, 0);
        check("imm8_din", mem_din, 16'hD3FB);
        check("imm8_wc", word_count, 1);

        // REG3 then IMM5 back to back
        drive(3'd0, 3'b101, 2'b00, 3'd1, 3'd2, 2'b01, 3'd0, 16'h0000);
        step();
        check("reg3_we", mem_write, 1);
        check("reg3_addr", mem_addr, 1);
        check("reg3_din", mem_din, 16'hA148);
        drive(3'd3, 3'b011, 2'b00, 3'd1, 3'd5, 2'd0, 3'd0, 16'h0004);
        step();
        check("imm5_we", mem_write, 1);
        check("imm5_addr", mem_addr, 2);
        check("imm5_din", mem_din, 16'h61A4);
        check("imm5_wc", word_count, 3);

        // IMM5 out of range (16) then in range (-16)
        imm = 16'h0010;
        step();
        check("imm5_rej_we", mem_write, 0);
        check("imm5_rej_err", err, 1);
        check("imm5_rej_wc", word_count, 3);
        imm = 16'hFFF0;
        step();
        check("imm5_neg_we", mem_write, 1);
        check("imm5_neg_addr", mem_addr, 3);
        check("imm5_neg_din", mem_din, 16'h61B0);
        check("err_sticky", err, 1);

        // REG2 ignores rn; BARE ignores everything below op
        drive(3'd1, 3'b010, 2'b11, 3'd7, 3'd3, 2'b10, 3'd5, 16'h1234);
        step();
        check("reg2_addr", mem_addr, 4);
        check("reg2_din", mem_din, 16'h5875);
        drive(3'd4, 3'b111, 2'b01, 3'd7, 3'd7, 2'b11, 3'd7, 16'hFFFF);
        step();
        check("bare_addr", mem_addr, 5);
        check("bare_din", mem_din, 16'hE800);

        // IMM8 boundaries: 128 rejected, -128 accepted
        drive(3'd2, 3'b001, 2'b01, 3'd2, 3'd0, 2'd0, 3'd0, 16'h0080);
        step();
        check("imm8_128_we", mem_write, 0);
        check("imm8_128_wc", word_count, 6);
        imm = 16'hFF80;
        step();
        check("imm8_m128_we", mem_write, 1);
        check("imm8_m128_addr", mem_addr, 6);
        check("imm8_m128_din", mem_din, 16'h2A80);

        // Idle cycle: outputs hold
        in_valid = 1'b0;
        step();
        check("hold_we", mem_write, 0);
        check("hold_addr", mem_addr, 6);
        check("hold_din", mem_din, 16'h2A80);

        // Illegal format, then restart clears err and address
        drive(3'd6, 3'b001, 2'b00, 3'd0, 3'd0, 2'd0, 3'd0, 16'h0000);
        step();
        check("fmt6_we", mem_write, 0);
        check("fmt6_wc", word_count, 7);
        start = 1'b1;
        drive(3'd4, 3'b100, 2'b00, 3'd0, 3'd0, 2'd0, 3'd0, 16'h0000);
        step();
        start = 1'b0;
        check("restart_err", err, 0);
        check("restart_wc", word_count, 0);
        check("restart_no_write", mem_write, 0);
        step();
        check("restart_addr", mem_addr, 0);
        check("restart_din", mem_din, 16'h8000);
        check("restart_we", mem_write, 1);

        // Asynchronous reset while a write is pending
        drive(3'd4, 3'b011, 2'b10, 3'd0, 3'd0, 2'd0, 3'd0, 16'h0000);
        step();
        check("pre_rst_we", mem_write, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_we", mem_write, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_din", mem_din, 0);
        check("mid_rst_wc", word_count, 0);
        check("mid_rst_ready", in_ready, 0);
        step();
        reset_n = 1'b1;
        step(); step();
        check("post_rst_ready", in_ready, 0);
        check("post_rst_we", mem_write, 0);
        in_valid = 1'b0;

        // Small instance: fill 4 words, fifth bundle must not be taken
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        s_in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s_opcode = 3'(k + 1);
            step();
            if (k < 4) begin
                check($sformatf("full_we_%0d", k), s_mem_write, 1);
                check($sformatf("full_addr_%0d", k), s_mem_addr, 32'(k));
                check($sformatf("full_din_%0d", k), s_mem_din, {16'h0000, 3'(k + 1), 2'b01, 11'h000});
                check($sformatf("full_done_%0d", k), s_done, (k == 3) ? 1 : 0);
                check($sformatf("full_ready_%0d", k), s_in_ready, (k == 3) ? 0 : 1);
            end else begin
                check("full_fifth_we", s_mem_write, 0);
                check("full_fifth_addr", s_mem_addr, 3);
            end
        end
        check("full_wc", s_word_count, 4);
        check("full_done_hold", s_done, 1);
        check("full_err", s_err, 0);
        s_in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
